// File: rtl/ascensor_pkg.sv
// Shared types for the elevator request path.
// Contents: default floor count and debounce length, floor index type,
// travel direction encoding, and the selection FSM state type.
package ascensor_pkg;

  localparam int unsigned NPisosDef    = 10;
  localparam int unsigned DebCiclosDef = 4;

  typedef logic [3:0] piso_t;

  typedef enum logic [1:0] {
    DirParado = 2'b00,
    DirSubir  = 2'b01,
    DirBajar  = 2'b10
  } dir_t;

  typedef enum logic [1:0] {
    StParado,
    StSubiendo,
    StBajando
  } estado_sel_t;

  // Direction output is a pure decode of the selection state.
  function automatic dir_t estado_a_dir(estado_sel_t e);
    case (e)
      StSubiendo: return DirSubir;
      StBajando:  return DirBajar;
      default:    return DirParado;
    endcase
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Single-button conditioning: 2-FF synchroniser, saturating run-length counter
// and rising-edge detector on the debounced level.
// Ports:
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   boton_i  raw button, asynchronous to clk_i
//   pulso_o  one-cycle pulse when a press is accepted
module antirrebote
  import ascensor_pkg::*;
#(
  parameter int unsigned DebCiclos = DebCiclosDef
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic boton_i,
  output logic pulso_o
);

  localparam int unsigned CntW = $clog2(DebCiclos + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebCiclos);

  logic            sync1_q, sync2_q, nivel_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            nivel;

  // Counter restarts on any low synced sample, so only an unbroken run
  // of DebCiclos highs raises the debounced level.
  always_comb begin
    cnt_d = '0;
    if (sync2_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  assign nivel   = (cnt_q == CntMax);
  assign pulso_o = nivel & ~nivel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
    end else begin
      sync1_q <= boton_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      nivel_q <= nivel;
    end
  end

endmodule

// File: rtl/gestor_solicitudes.sv
// Elevator request stage: debounces floor buttons, latches pending calls,
// clears a call when its floor is served, and picks the next target floor
// and travel direction with a SCAN policy.
// Ports:
//   clk_i             system clock
//   rst_ni            asynchronous active-low reset
//   botones_i         raw floor buttons (async, active-high)
//   piso_actual_i     current floor index
//   piso_atendido_i   one-cycle pulse: doors opened at piso_actual_i
//   luces_o           pending-call lamps
//   destino_o         selected target floor
//   destino_valido_o  destino_o holds a pending call
//   direccion_o       00 stopped, 01 up, 10 down
module gestor_solicitudes
  import ascensor_pkg::*;
#(
  parameter int unsigned NPisos    = NPisosDef,
  parameter int unsigned DebCiclos = DebCiclosDef
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NPisos-1:0] botones_i,
  input  piso_t             piso_actual_i,
  input  logic              piso_atendido_i,
  output logic [NPisos-1:0] luces_o,
  output piso_t             destino_o,
  output logic              destino_valido_o,
  output dir_t              direccion_o
);

  logic [NPisos-1:0] pulsos, limpiar, luces_q, luces_d;
  piso_t             destino_q, destino_d;
  logic              valido_q, valido_d;
  estado_sel_t       estado_q, estado_d;
  logic              piso_ok;

  for (genvar g = 0; g < NPisos; g++) begin : gen_deb
    antirrebote #(
      .DebCiclos(DebCiclos)
    ) u_antirrebote (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .boton_i(botones_i[g]),
      .pulso_o(pulsos[g])
    );
  end

  assign piso_ok = {1'b0, piso_actual_i} < 5'(NPisos);

  // Clear mask is applied after the set so a same-cycle clear wins.
  always_comb begin
    limpiar = '0;
    for (int unsigned i = 0; i < NPisos; i++) begin
      limpiar[i] = piso_atendido_i && piso_ok && (piso_actual_i == piso_t'(i));
    end
    luces_d = (luces_q | pulsos) & ~limpiar;
  end

  // Nearest pending call strictly above and strictly below the current floor.
  logic  hay_aqui, hay_arriba, hay_abajo;
  piso_t arriba, abajo, dist_arriba, dist_abajo;

  always_comb begin
    hay_aqui   = 1'b0;
    hay_arriba = 1'b0;
    hay_abajo  = 1'b0;
    arriba     = '0;
    abajo      = '0;
    for (int unsigned i = 0; i < NPisos; i++) begin
      if (luces_q[i]) begin
        if (piso_t'(i) == piso_actual_i) hay_aqui = 1'b1;
        if (piso_t'(i) > piso_actual_i && !hay_arriba) begin
          hay_arriba = 1'b1;
          arriba     = piso_t'(i);
        end
        if (piso_t'(i) < piso_actual_i) begin
          hay_abajo = 1'b1;
          abajo     = piso_t'(i);
        end
      end
    end
    dist_arriba = arriba - piso_actual_i;
    dist_abajo  = piso_actual_i - abajo;
  end

  logic ir_arriba;

  always_comb begin
    estado_d  = estado_q;
    destino_d = destino_q;
    valido_d  = 1'b0;
    ir_arriba = 1'b0;
    if (!piso_ok || luces_q == '0) begin
      estado_d = StParado;
    end else if (hay_aqui) begin
      destino_d = piso_actual_i;
      valido_d  = 1'b1;
    end else begin
      valido_d = 1'b1;
      unique case (estado_q)
        StSubiendo: ir_arriba = hay_arriba;
        StBajando:  ir_arriba = !hay_abajo;
        // Stopped: nearest call, ties go up.
        default:    ir_arriba = hay_arriba && (!hay_abajo || dist_arriba <= dist_abajo);
      endcase
      if (ir_arriba) begin
        destino_d = arriba;
        estado_d  = StSubiendo;
      end else begin
        destino_d = abajo;
        estado_d  = StBajando;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      luces_q   <= '0;
      destino_q <= '0;
      valido_q  <= 1'b0;
      estado_q  <= StParado;
    end else begin
      luces_q   <= luces_d;
      destino_q <= destino_d;
      valido_q  <= valido_d;
      estado_q  <= estado_d;
    end
  end

  assign luces_o          = luces_q;
  assign destino_o        = destino_q;
  assign destino_valido_o = valido_q;
  assign direccion_o      = estado_a_dir(estado_q);

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Scoreboard bench for gestor_solicitudes: a behavioural model pushes the
// expected outputs after every clock edge, a monitor pops and compares on the
// falling edge. Directed scenarios are followed by a randomized phase.
module tb_gestor_solicitudes;

  localparam int N   = 10;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] botones;
  logic [3:0]   piso_actual;
  logic         piso_atendido;
  logic [N-1:0] luces;
  logic [3:0]   destino;
  logic         destino_valido;
  logic [1:0]   direccion;

  gestor_solicitudes #(
    .NPisos   (N),
    .DebCiclos(DEB)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .botones_i       (botones),
    .piso_actual_i   (piso_actual),
    .piso_atendido_i (piso_atendido),
    .luces_o         (luces),
    .destino_o       (destino),
    .destino_valido_o(destino_valido),
    .direccion_o     (direccion)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] luces;
    logic [3:0]   dest;
    logic         val;
    logic [1:0]   dir;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [N-1:0] m_luces;
  int           m_dest;
  bit           m_val;
  int           m_st;      // 0 stopped, 1 going up, 2 going down
  int           run[N];    // consecutive high raw samples
  bit [2:0]     acc[N];    // "run just reached DEB" flags, delayed by the sync stages

  always @(posedge clk or negedge rst_n) begin
    int p, up, dn;
    bit go_up;
    logic [N-1:0] press;
    if (!rst_n) begin
      m_luces = '0;
      m_dest  = 0;
      m_val   = 0;
      m_st    = 0;
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
        acc[i] = '0;
      end
      sb.delete();
    end else begin
      p = int'(piso_actual);
      // Selection on the calls held before this edge.
      up = -1;
      dn = -1;
      for (int j = 0; j < N; j++) begin
        if (m_luces[j]) begin
          if (j > p && up < 0) up = j;
          if (j < p) dn = j;
        end
      end
      if (p >= N || m_luces == '0) begin
        m_st  = 0;
        m_val = 0;
      end else if (m_luces[p]) begin
        m_dest = p;
        m_val  = 1;
      end else begin
        m_val = 1;
        if (m_st == 1)      go_up = (up >= 0);
        else if (m_st == 2) go_up = (dn < 0);
        else                go_up = (up >= 0) && (dn < 0 || (up - p) <= (p - dn));
        if (go_up) begin
          m_dest = up;
          m_st   = 1;
        end else begin
          m_dest = dn;
          m_st   = 2;
        end
      end
      // A press lands three edges after the raw run first reaches DEB samples.
      for (int i = 0; i < N; i++) begin
        press[i] = acc[i][2];
        run[i]   = botones[i] ? ((run[i] > DEB) ? run[i] : run[i] + 1) : 0;
        acc[i]   = {acc[i][1:0], (run[i] == DEB)};
      end
      m_luces = m_luces | press;
      if (piso_atendido && p < N) m_luces[p] = 1'b0;
      sb.push_back({m_luces, 4'(m_dest), m_val, 2'(m_st)});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_luces", 32'(luces), 32'(e.luces));
      chk("sb_valido", 32'(destino_valido), 32'(e.val));
      chk("sb_direccion", 32'(direccion), 32'(e.dir));
      if (e.val) chk("sb_destino", 32'(destino), 32'(e.dest));
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic servir(int piso);
    piso_actual   = 4'(piso);
    piso_atendido = 1'b1;
    step(1);
    piso_atendido = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    botones       = '0;
    piso_actual   = '0;
    piso_atendido = 1'b0;
    #3;
    chk("reset_luces", 32'(luces), 32'h0);
    chk("reset_valido", 32'(destino_valido), 32'h0);
    chk("reset_dir", 32'(direccion), 32'h0);
    step(3);
    rst_n = 1'b1;

    // 1: single call above, latency check.
    piso_actual = 4'd2;
    botones[7]  = 1'b1;
    step(6);
    chk("t1_luces_early", 32'(luces), 32'h0);
    step(1);
    chk("t1_luces", 32'(luces), 32'h080);
    step(1);
    chk("t1_destino", 32'(destino), 32'd7);
    chk("t1_valido", 32'(destino_valido), 32'd1);
    chk("t1_dir", 32'(direccion), 32'd1);
    step(2);
    botones[7] = 1'b0;
    servir(7);
    step(3);

    // 2: glitch shorter than the debounce window.
    botones[3] = 1'b1;
    step(3);
    botones[3] = 1'b0;
    step(8);
    chk("t2_luces", 32'(luces), 32'h0);
    chk("t2_valido", 32'(destino_valido), 32'd0);

    // 3: equidistant calls, tie goes up, then reverse.
    piso_actual = 4'd3;
    botones[5]  = 1'b1;
    botones[1]  = 1'b1;
    step(10);
    botones = '0;
    step(2);
    chk("t3_destino_up", 32'(destino), 32'd5);
    chk("t3_dir_up", 32'(direccion), 32'd1);
    servir(5);
    chk("t3_luces", 32'(luces), 32'h002);
    step(1);
    chk("t3_destino_dn", 32'(destino), 32'd1);
    chk("t3_dir_dn", 32'(direccion), 32'd2);
    servir(1);
    step(3);

    // 4: set and clear in the same cycle; held button never re-sets.
    piso_actual = 4'd0;
    botones[4]  = 1'b1;
    step(6);
    servir(4);
    chk("t4_clear_wins", 32'(luces[4]), 32'd0);
    step(10);
    chk("t4_held", 32'(luces[4]), 32'd0);
    botones[4] = 1'b0;
    step(3);
    botones[4] = 1'b1;
    step(8);
    chk("t4_repress", 32'(luces[4]), 32'd1);
    botones[4] = 1'b0;
    step(2);

    // 5: asynchronous reset mid-cycle.
    botones[2] = 1'b1;
    botones[8] = 1'b1;
    step(8);
    botones = '0;
    step(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_luces", 32'(luces), 32'h0);
    chk("t5_destino", 32'(destino), 32'h0);
    chk("t5_valido", 32'(destino_valido), 32'h0);
    chk("t5_dir", 32'(direccion), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("t5_post_luces", 32'(luces), 32'h0);
    chk("t5_post_dir", 32'(direccion), 32'h0);

    // 6: out-of-range floor.
    piso_actual = 4'd12;
    botones[6]  = 1'b1;
    botones[9]  = 1'b1;
    step(10);
    botones = '0;
    step(2);
    chk("t6_dir", 32'(direccion), 32'd0);
    chk("t6_valido", 32'(destino_valido), 32'd0);
    chk("t6_luces", 32'(luces), 32'h240);
    piso_atendido = 1'b1;
    step(2);
    piso_atendido = 1'b0;
    chk("t6_ignored", 32'(luces), 32'h240);

    // Randomized phase, checked by the scoreboard.
    piso_actual = 4'd4;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 11) == 0) botones[i] = ~botones[i];
      end
      if ($urandom_range(0, 7) == 0) begin
        piso_actual = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, N - 1));
      end
      piso_atendido = ($urandom_range(0, 4) == 0);
      step(1);
    end
    piso_atendido = 1'b0;
    botones       = '0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
